xyz_change_logger: RTL and testbench

Downstream consumer of the x/y/z outputs of `dut`. It samples `{x,y,z}` every enabled cycle and detects value changes. Each change is logged as a timestamped record into an internal FIFO, drained through a valid/ready interface. Records that cannot be stored are counted. It gives the bench and any later checker a compact event stream instead of per-cycle output polling.

---
 rtl/xyz_log_pkg.sv | 18 +
 rtl/xyz_change_logger_if.sv | 25 ++
 rtl/xyz_change_logger_fifo.sv | 64 ++++++
 rtl/xyz_change_logger.sv | 106 ++++++++++
 tb/tb_xyz_change_logger.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xyz_log_pkg.sv
// Shared types and constants for the xyz change logger.
// Record layout is {ts, old_xyz, new_xyz}, timestamp in the MSBs.
package xyz_log_pkg;

    localparam int TS_W_DEF = 16;
    localparam int OVF_W    = 8;

    typedef logic [2:0] xyz_t;

    // Default-width record; modules with another TS_W declare a local
    // struct of identical shape.
    typedef struct packed {
        logic [TS_W_DEF-1:0] ts;
        xyz_t                old_xyz;
        xyz_t                new_xyz;
    } ev_rec_t;

endpackage

// File: rtl/xyz_change_logger_if.sv
// Event stream handshake between the logger and its consumer.
// master drives valid/data/level, slave returns ready.
interface xyz_change_logger_if #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
);
    logic                     ev_valid;
    logic                     ev_ready;
    logic [TS_W+5:0]          ev_data;
    logic [$clog2(DEPTH):0]   ev_level;

    modport master (
        output ev_valid,
        output ev_data,
        output ev_level,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_data,
        input  ev_level,
        output ev_ready
    );
endinterface

// File: rtl/xyz_change_logger_fifo.sv
// Synchronous FIFO with occupancy count and async active-high reset.
// Head data reads 0 while empty so the output is defined after reset.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_level;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == FULL_LVL);
    assign o_level = r_level;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd];

    // A pop frees a slot, so a full FIFO still accepts a concurrent push.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_wdata;
        end
    end

    // Pointers and occupancy; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/xyz_change_logger.sv
// Samples {x,y,z}, logs each change as a timestamped record into a
// FIFO and counts records lost to a full FIFO.
module xyz_change_logger
    import xyz_log_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    input  logic             clr_ovf,
    xyz_change_logger_if.master ev,
    output logic [OVF_W-1:0] ovf_cnt,
    output logic             ovf_sticky
);
    typedef struct packed {
        logic [TS_W-1:0] ts;
        xyz_t            old_xyz;
        xyz_t            new_xyz;
    } rec_t;

    logic [TS_W-1:0]        r_ts;
    xyz_t                   r_prev;
    logic                   r_base_vld;
    bit   [2:0]             w_xyz;
    logic                   w_chg;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_drop;
    rec_t                   w_rec;
    logic [TS_W+5:0]        w_rdata;
    logic [$clog2(DEPTH):0] w_level;

    // Two-state view of the inputs: X/Z compare as 0.
    assign w_xyz = {x, y, z};

    assign w_chg = en && r_base_vld && (xyz_t'(w_xyz) != r_prev);

    assign w_rec = '{ts: r_ts, old_xyz: r_prev, new_xyz: xyz_t'(w_xyz)};

    assign w_pop  = ev.ev_ready && !w_empty;
    assign w_drop = w_chg && w_full && !w_pop;

    assign ev.ev_valid = !w_empty;
    assign ev.ev_data  = w_rdata;
    assign ev.ev_level = w_level;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TS_W + 6)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_chg),
        .i_pop   (ev.ev_ready),
        .i_wdata (w_rec),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // Free-running timestamp, wraps modulo 2^TS_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // Baseline learn on first enabled sample, then track every change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev     <= '0;
            r_base_vld <= 1'b0;
        end else if (en && !r_base_vld) begin
            r_prev     <= xyz_t'(w_xyz);
            r_base_vld <= 1'b1;
        end else if (w_chg) begin
            r_prev <= xyz_t'(w_xyz);
        end
    end

    // Drop accounting; a clear in the same cycle as a drop wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt    <= '0;
            ovf_sticky <= 1'b0;
        end else if (clr_ovf) begin
            ovf_cnt    <= '0;
            ovf_sticky <= 1'b0;
        end else if (w_drop) begin
            if (ovf_cnt != '1) begin
                ovf_cnt <= ovf_cnt + 1'b1;
            end
            ovf_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xyz_change_logger.sv
// Randomised and directed bench for xyz_change_logger against a
// queue-based model; TS_W=16 and TS_W=4 instances share stimulus.
module tb_xyz_change_logger;
    import xyz_log_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic x = 1'b0;
    logic y = 1'b0;
    logic z = 1'b0;
    logic clr_ovf = 1'b0;
    logic [7:0] ovf16;
    logic [7:0] ovf4;
    logic st16;
    logic st4;

    xyz_change_logger_if #(.DEPTH(DEPTH), .TS_W(16)) ev16();
    xyz_change_logger_if #(.DEPTH(DEPTH), .TS_W(4))  ev4();

    always #5 clk = ~clk;

    xyz_change_logger #(.DEPTH(DEPTH), .TS_W(16)) u_dut16 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .x          (x),
        .y          (y),
        .z          (z),
        .clr_ovf    (clr_ovf),
        .ev         (ev16.master),
        .ovf_cnt    (ovf16),
        .ovf_sticky (st16)
    );

    xyz_change_logger #(.DEPTH(DEPTH), .TS_W(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .x          (x),
        .y          (y),
        .z          (z),
        .clr_ovf    (clr_ovf),
        .ev         (ev4.master),
        .ovf_cnt    (ovf4),
        .ovf_sticky (st4)
    );

    typedef struct {
        int unsigned ts;
        bit [2:0]    o;
        bit [2:0]    n;
    } mrec_t;

    int n_cmp = 0;
    int n_err = 0;

    mrec_t       mq[$];
    int unsigned m_ts;
    bit          m_base;
    bit [2:0]    m_prev;
    int          m_ovf;
    bit          m_st;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_ts   = 0;
        m_base = 1'b0;
        m_prev = 3'b000;
        m_ovf  = 0;
        m_st   = 1'b0;
    endtask

    // Advance the model by one clock edge with the applied inputs.
    task automatic m_step(input bit e, input bit [2:0] v,
                          input bit rdy, input bit clr);
        bit    pop;
        bit    full;
        bit    have;
        bit    drop;
        mrec_t r;
        pop  = rdy && (mq.size() != 0);
        full = (mq.size() == DEPTH);
        have = 1'b0;
        drop = 1'b0;
        r    = '{ts: 0, o: 3'b000, n: 3'b000};
        if (e && !m_base) begin
            m_base = 1'b1;
            m_prev = v;
        end else if (e && v != m_prev) begin
            r    = '{ts: m_ts, o: m_prev, n: v};
            have = 1'b1;
            drop = full && !pop;
            m_prev = v;
        end
        if (pop) void'(mq.pop_front());
        if (have && !drop) mq.push_back(r);
        if (clr) begin
            m_ovf = 0;
            m_st  = 1'b0;
        end else if (drop) begin
            if (m_ovf < 255) m_ovf++;
            m_st = 1'b1;
        end
        m_ts++;
    endtask

    task automatic check_outputs();
        bit [21:0] e16;
        bit [9:0]  e4;
        chk("valid16", ev16.ev_valid, mq.size() != 0);
        chk("valid4", ev4.ev_valid, mq.size() != 0);
        chk("level16", ev16.ev_level, mq.size());
        chk("level4", ev4.ev_level, mq.size());
        chk("ovf16", ovf16, m_ovf);
        chk("ovf4", ovf4, m_ovf);
        chk("sticky16", st16, m_st);
        chk("sticky4", st4, m_st);
        if (mq.size() != 0) begin
            e16 = {mq[0].ts[15:0], mq[0].o, mq[0].n};
            e4  = {mq[0].ts[3:0], mq[0].o, mq[0].n};
            chk("data16", ev16.ev_data, e16);
            chk("data4", ev4.ev_data, e4);
        end
    endtask

    task automatic cycle(input bit e, input bit [2:0] v,
                         input bit rdy, input bit clr);
        en = e;
        {x, y, z} = v;
        ev16.ev_ready = rdy;
        ev4.ev_ready  = rdy;
        clr_ovf = clr;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        m_step(e, v, rdy, clr);
        #1;
    endtask

    task automatic toggles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, ~m_prev, rdy, 1'b0);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 3'b000, 1'b1, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", ev16.ev_valid, 1'b0);
        chk("rst_level", ev16.ev_level, 0);
        chk("rst_level4", ev4.ev_level, 0);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        ev16.ev_ready = 1'b0;
        ev4.ev_ready  = 1'b0;
        m_reset();
        #2;
        chk("init_valid", ev16.ev_valid, 1'b0);
        chk("init_data", ev16.ev_data, 0);
        chk("init_level", ev16.ev_level, 0);
        chk("init_ovf", ovf16, 0);
        chk("init_sticky", st16, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) cycle(1'b1, 3'b110, 1'b1, 1'b0);
        chk("const_level", ev16.ev_level, 0);
        chk("const_valid", ev16.ev_valid, 1'b0);

        cycle(1'b1, 3'b111, 1'b1, 1'b0);
        cycle(1'b1, 3'b011, 1'b1, 1'b0);
        cycle(1'b1, 3'b001, 1'b1, 1'b0);
        cycle(1'b1, 3'b000, 1'b1, 1'b0);
        drain(3);

        toggles(DEPTH + 3, 1'b0);
        chk("ovf_level", ev16.ev_level, DEPTH);
        chk("ovf_cnt3", ovf16, 3);
        chk("ovf_sticky", st16, 1'b1);
        drain(DEPTH + 1);
        cycle(1'b0, 3'b000, 1'b1, 1'b1);
        chk("clr_cnt", ovf16, 0);
        chk("clr_sticky", st16, 1'b0);

        toggles(DEPTH, 1'b0);
        cycle(1'b1, ~m_prev, 1'b1, 1'b0);
        chk("full_pp_level", ev16.ev_level, DEPTH);
        chk("full_pp_ovf", ovf16, 0);
        drain(DEPTH + 1);

        cycle(1'b0, 3'b000, 1'b1, 1'b0);
        cycle(1'b0, 3'b111, 1'b1, 1'b0);
        cycle(1'b0, 3'b000, 1'b1, 1'b0);
        cycle(1'b1, 3'b000, 1'b1, 1'b0);
        cycle(1'b1, 3'b000, 1'b1, 1'b0);
        chk("en0_level", ev16.ev_level, 0);

        toggles(5, 1'b0);
        chk("pre_rst_level", ev16.ev_level, 5);
        do_reset();
        cycle(1'b1, 3'b101, 1'b1, 1'b0);
        cycle(1'b1, 3'b101, 1'b1, 1'b0);
        chk("rebase_valid", ev16.ev_valid, 1'b0);

        toggles(300, 1'b0);
        chk("ovf_sat", ovf16, 255);
        cycle(1'b1, ~m_prev, 1'b0, 1'b1);
        chk("clr_wins", ovf16, 0);
        drain(DEPTH + 1);

        for (int i = 0; i < 3000; i++) begin
            bit       e;
            bit [2:0] v;
            e = ($urandom_range(0, 9) < 8);
            v = ($urandom_range(0, 3) == 0) ? m_prev : 3'($urandom);
            cycle(e, v, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 199) == 0);
        end
        drain(DEPTH + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
